// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS AXI-Stream sources onto one egress stream.
// A grant is held until the granted source's tlast beat is accepted; tid reports the source.
//
// state     | meaning
// ST_IDLE   | arbitration cycle, no beats move, grant chosen from enabled requesters
// ST_LOCKED | granted source owns the egress until its tlast beat is accepted
module axis_packet_rr_arbiter #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int NUM_INPUTS      = 4
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [NUM_INPUTS*AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep,
  input  logic [NUM_INPUTS*AXIS_DEST_WIDTH-1:0]  axis_in_tdest,
  input  logic [NUM_INPUTS-1:0]                  axis_in_tlast,
  input  logic [NUM_INPUTS-1:0]                  axis_in_tvalid,
  output logic [NUM_INPUTS-1:0]                  axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]            axis_out_tkeep,
  output logic [AXIS_DEST_WIDTH-1:0]             axis_out_tdest,
  output logic [AXIS_ID_WIDTH-1:0]               axis_out_tid,
  output logic                                   axis_out_tlast,
  output logic                                   axis_out_tvalid,
  input  logic                                   axis_out_tready,
  input  logic [NUM_INPUTS-1:0]                  input_enable,
  output logic                                   grant_active,
  output logic [$clog2(NUM_INPUTS)-1:0]          grant_index
);

  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   grant_idx, grant_idx_nxt;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [NUM_INPUTS-1:0] req;
  logic               sel_tvalid;

  assign req = axis_in_tvalid & input_enable;

  // Scan from the highest offset down so the entry closest to rr_ptr wins.
  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (req[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin : out_mux
    axis_out_tdata = '0;
    axis_out_tkeep = '0;
    axis_out_tdest = '0;
    axis_out_tlast = 1'b0;
    sel_tvalid     = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        axis_out_tdata = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        axis_out_tkeep = axis_in_tkeep[i*KEEP_W +: KEEP_W];
        axis_out_tdest = axis_in_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
        axis_out_tlast = axis_in_tlast[i];
        sel_tvalid     = axis_in_tvalid[i];
      end
    end
    axis_out_tid              = '0;
    axis_out_tid[IDX_W-1:0]   = grant_idx;
  end

  always_comb begin : fsm_comb
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_idx_nxt   = grant_idx;
    axis_out_tvalid = 1'b0;
    axis_in_tready  = '0;
    grant_active    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_idx_nxt = pick;
          state_nxt     = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        grant_active              = 1'b1;
        axis_out_tvalid           = sel_tvalid;
        axis_in_tready[grant_idx] = axis_out_tready;
        if (sel_tvalid && axis_out_tready && axis_out_tlast) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_idx_nxt;
    end
  end

  assign grant_index = grant_idx;

endmodule
